segre_cache_mem_arbiter: RTL
============================

# segre_cache_mem_arbiter

Memory-side responder for the cache-to-memory request protocol built on `cache_mem_req_t`. It accepts line requests from the instruction and data caches and queues them in order in an `ARB_BUF_SIZE`-entry circular buffer. It issues them one at a time to the memory port and routes read-line responses back to the requesting cache by `cache_id`. It sits between the two L1 caches and main memory.

## Interface
Parameters (from the shared package):
- `ARB_BUF_SIZE`, 16, queue depth; must be a power of two.
- `ARB_PTR_SIZE`, `$clog2(ARB_BUF_SIZE)`, pointer width.

Ports:
- `clk_i` in 1 — the single clock.
- `rst_i` in 1 — reset; synchronous, active-high.
- `ic_req_valid_i` in 1 — icache request valid.
- `ic_req_i` in `cache_mem_req_t` (163) — icache request.
- `ic_req_ready_o` out 1 — icache request accepted this cycle when high with valid.
- `dc_req_valid_i` in 1, `dc_req_i` in `cache_mem_req_t`, `dc_req_ready_o` out 1 — same, for the dcache.
- `mem_req_valid_o` out 1, `mem_req_o` out `cache_mem_req_t`, `mem_req_ready_i` in 1 — request to memory.
- `mem_rsp_valid_i` in 1 — memory read data valid.
- `mem_rsp_line_i` in 128 — memory read line.
- `ic_rsp_valid_o` out 1, `ic_rsp_line_o` out 128 — line returned to the icache.
- `dc_rsp_valid_o` out 1, `dc_rsp_line_o` out 128 — line returned to the dcache.
- `buf_count_o` out `ARB_PTR_SIZE+1` — current queue occupancy.

## Operation
- **Enqueue:** at most one request per cycle.
  - If only one source is valid, it is chosen.
  - If both are valid, the source other than the last-granted source wins (round-robin). The last-granted source resets to ICACHE, so the dcache wins the first tie.
  - The chosen source's ready is high iff the registered count is below `ARB_BUF_SIZE`. The other source's ready is 0.
  - The request is stored verbatim. Its `cache_id` is forced to the port it arrived on.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when the registered count is nonzero.
  - ISSUE: `mem_req_valid_o`=1 and `mem_req_o`=head entry. On `mem_req_ready_i` the head is popped.
    - A popped request with `wr`=1 goes to IDLE; writes produce no cache response.
    - A popped request with `rd`=1 goes to WAIT.
  - WAIT: on `mem_rsp_valid_i`, capture the line and the head's saved `cache_id` → RESP.
  - RESP: pulse `ic_rsp_valid_o` or `dc_rsp_valid_o` for exactly one cycle with the captured line, then → IDLE.
- **Ordering:** strict FIFO across both sources; a read following a write to the same address always observes memory after the write.
- **Ignored inputs:** `mem_rsp_valid_i` outside WAIT is ignored. `rsp_line` outputs hold their last value when valid is low.
- **Illegal requests:** `rd`==`wr` is illegal at enqueue. An assertion flags it, and behaviour is undefined.

## Timing
- **Reset values:** all valid/ready outputs 0, `buf_count_o`=0, pointers 0, FSM IDLE, line outputs 0, last-grant ICACHE.
- **Issue latency:** an enqueue handshake at cycle t gives count visible at t+1, ISSUE at t+2, `mem_req_valid_o` high at t+2.
- **Read round trip:** a memory response at cycle r gives the cache `rsp_valid` at r+1. The next ISSUE is at r+3 at the earliest.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
- **Full:** ready is based on the registered count, so no push occurs while full even if a pop happens that cycle.
- **Wrap-around:** pointers wrap modulo `ARB_BUF_SIZE`. Full/empty is derived from the count, not from pointer equality.
- **Held request:** `mem_req_o` stays stable while `mem_req_valid_o`=1 and ready is low.
- **Reset mid-operation:** the queue is flushed, any in-flight memory request or response is discarded, and no response pulse is emitted.

## Structure
- `cache_mem_req_t`, `cache_id_e`, `ARB_BUF_SIZE`, `ARB_PTR_SIZE` and `CACHE_LINE_SIZE_BITS` live in the shared package.
- The FSM state enum (`arb_state_e`) is also added to the package.
- The circular buffer is a sub-module, `segre_arb_fifo`: push/pop/count/head, parameterized by depth and element type.
- Arbitration, FSM and response routing live in the top module.

## Test plan
- **Single icache read:** icache read at addr 0x100 → `mem_req_valid_o` at t+2 with `cache_id`=ICACHE, `rd`=1. Memory returns line 0xDEADBEEF_… → `ic_rsp_valid_o` for one cycle with that line; `dc_rsp_valid_o` stays 0.
- **Tie arbitration:** both sources valid for 4 cycles from reset → accepted order DC, IC, DC, IC; memory sees them in that order.
- **Full queue:** hold `mem_req_ready_i`=0, push 16 dcache writes → `buf_count_o`=16, both readies 0. Drop the backpressure → the 16 writes issue in order, with no cache responses.
- **Write then read:** dcache write to 0x40 with data A, then icache read of 0x40; the memory model returns stored data → `ic_rsp_line_o`=A.
- **Reset mid-read:** assert `rst_i` in WAIT, then pulse `mem_rsp_valid_i` → no `rsp_valid` pulse, count 0, FSM IDLE.
- **Wrap-around:** 40 mixed requests with random memory stalls → all responses match the reference model, routed to the correct cache, and pointers wrap with no loss.

Source files
------------

// File: rtl/segre_cache_mem_arbiter_pkg.sv
// rtl/segre_cache_mem_arbiter_pkg.sv - shared types and sizes for the cache-to-memory request path
package segre_cache_mem_arbiter_pkg;

   localparam int ARB_BUF_SIZE         = 16;
   localparam int ARB_PTR_SIZE         = $clog2(ARB_BUF_SIZE);
   localparam int CACHE_LINE_SIZE_BITS = 128;
   localparam int ADDR_SIZE            = 32;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } cache_id_e;

   // 32 + 128 + 1 + 1 + 1 = 163 bits
   typedef struct packed {
      logic [ADDR_SIZE-1:0]            addr;
      logic [CACHE_LINE_SIZE_BITS-1:0] data;
      logic                            rd;
      logic                            wr;
      cache_id_e                       cache_id;
   } cache_mem_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/segre_arb_fifo.sv
// rtl/segre_arb_fifo.sv - circular request buffer with registered occupancy count
module segre_arb_fifo #(
   parameter int  DEPTH = 16,
   parameter type T     = logic
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  T                        data_i,
   input  logic                    pop_i,
   output T                        head_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int PW = $clog2(DEPTH);

   T                mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;
   logic            do_push;
   logic            do_pop;

   // Full/empty come from the count, never from pointer equality
   assign do_push = push_i && (count < (PW+1)'(DEPTH));
   assign do_pop  = pop_i && (count != '0);
   assign head_o  = mem[rd_ptr];
   assign count_o = count;

   // Entry storage needs no reset: an entry is only meaningful while counted
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

   // Pointers wrap on their own because DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/segre_cache_mem_arbiter.sv
// rtl/segre_cache_mem_arbiter.sv - queues icache/dcache line requests and serves them to memory in order
module segre_cache_mem_arbiter
   import segre_cache_mem_arbiter_pkg::*;
(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            ic_req_valid_i,
   input  cache_mem_req_t                  ic_req_i,
   output logic                            ic_req_ready_o,
   input  logic                            dc_req_valid_i,
   input  cache_mem_req_t                  dc_req_i,
   output logic                            dc_req_ready_o,
   output logic                            mem_req_valid_o,
   output cache_mem_req_t                  mem_req_o,
   input  logic                            mem_req_ready_i,
   input  logic                            mem_rsp_valid_i,
   input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
   output logic                            ic_rsp_valid_o,
   output logic [CACHE_LINE_SIZE_BITS-1:0] ic_rsp_line_o,
   output logic                            dc_rsp_valid_o,
   output logic [CACHE_LINE_SIZE_BITS-1:0] dc_rsp_line_o,
   output logic [ARB_PTR_SIZE:0]           buf_count_o
);

   arb_state_e                      state;
   arb_state_e                      state_next;
   cache_id_e                       last_grant;
   cache_id_e                       rsp_id;
   cache_mem_req_t                  enq_req;
   cache_mem_req_t                  head;
   logic                            ic_sel;
   logic                            dc_sel;
   logic                            not_full;
   logic                            push;
   logic                            pop;
   logic [ARB_PTR_SIZE:0]           count;
   logic [CACHE_LINE_SIZE_BITS-1:0] ic_line;
   logic [CACHE_LINE_SIZE_BITS-1:0] dc_line;

   // Round-robin pick: on a tie the cache not granted last time wins; the tag follows the port
   always_comb begin
      ic_sel           = ic_req_valid_i && (!dc_req_valid_i || (last_grant == DCACHE));
      dc_sel           = dc_req_valid_i && !ic_sel;
      enq_req          = ic_sel ? ic_req_i : dc_req_i;
      enq_req.cache_id = ic_sel ? ICACHE : DCACHE;
   end

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot early
   assign not_full       = !rst_i && (count < (ARB_PTR_SIZE+1)'(ARB_BUF_SIZE));
   assign ic_req_ready_o = ic_sel && not_full;
   assign dc_req_ready_o = dc_sel && not_full;
   assign push           = ic_req_ready_o || dc_req_ready_o;
   assign pop            = (state == ISSUE) && mem_req_ready_i;
   assign buf_count_o    = count;
   assign ic_rsp_line_o  = ic_line;
   assign dc_rsp_line_o  = dc_line;

   segre_arb_fifo #(
      .DEPTH (ARB_BUF_SIZE),
      .T     (cache_mem_req_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (enq_req),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // One request in flight at a time; writes complete on the handshake, reads wait for data
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count != '0) state_next = ISSUE;
         ISSUE:   if (mem_req_ready_i) state_next = head.wr ? IDLE : WAIT;
         WAIT:    if (mem_rsp_valid_i) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory request and one-cycle response pulses decoded from the state
   always_comb begin
      mem_req_valid_o = (state == ISSUE);
      mem_req_o       = (state == ISSUE) ? head : '0;
      ic_rsp_valid_o  = (state == RESP) && (rsp_id == ICACHE);
      dc_rsp_valid_o  = (state == RESP) && (rsp_id == DCACHE);
   end

   // Grant history, owner of the outstanding read, and the per-cache line holding registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant <= ICACHE;
         rsp_id     <= ICACHE;
         ic_line    <= '0;
         dc_line    <= '0;
      end else begin
         if (push) last_grant <= ic_sel ? ICACHE : DCACHE;
         if (pop)  rsp_id     <= head.cache_id;
         if ((state == WAIT) && mem_rsp_valid_i) begin
            if (rsp_id == ICACHE) ic_line <= mem_rsp_line_i;
            else                  dc_line <= mem_rsp_line_i;
         end
      end
   end

   illegal_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
      push |-> (enq_req.rd != enq_req.wr));

endmodule
